spi_minion: RTL and testbench

Peripheral-side SPI endpoint that pairs with the chip's SPI master on the same four-wire bus (cs, sclk, mosi, miso). It oversamples the bus with the system clock, shifts one nbits-bit word in from mosi, and simultaneously shifts one nbits-bit word out on miso per chip-select frame. Received words leave on a val/rdy stream, and words to transmit arrive on a val/rdy stream. It sits at the far end of the SPI link in bench models and in loopback configurations of the SoC.

---
 rtl/spi_minion_if.sv | 28 ++
 rtl/spi_minion.sv | 151 +++++++++++++++
 tb/tb_spi_minion.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_minion_if.sv
// Bus bundle for spi_minion: the four SPI wires plus the tx/rx val/rdy streams.
// The master modport is the side that drives the SPI wires and the streams.
interface spi_minion_if #(
  parameter int nbits = 34
);
  logic             cs;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic             tx_val;
  logic             tx_rdy;
  logic [nbits-1:0] tx_msg;
  logic             rx_val;
  logic             rx_rdy;
  logic [nbits-1:0] rx_msg;
  logic             rx_overflow;
  logic             frame_err;

  modport master (
    output cs, sclk, mosi, tx_val, tx_msg, rx_rdy,
    input  miso, tx_rdy, rx_val, rx_msg, rx_overflow, frame_err
  );

  modport slave (
    input  cs, sclk, mosi, tx_val, tx_msg, rx_rdy,
    output miso, tx_rdy, rx_val, rx_msg, rx_overflow, frame_err
  );
endinterface

// File: rtl/spi_minion.sv
// SPI peripheral endpoint (CPOL=0, CPHA=0): oversamples cs/sclk/mosi with clk,
// shifts one nbits word each way per chip-select frame, val/rdy streams on both sides.
module spi_minion #(
  parameter int nbits = 34
) (
  input  logic         clk,
  input  logic         reset,
  spi_minion_if.slave  bus
);

  localparam int CNT_W = $clog2(nbits + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(nbits);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(nbits + 1);

  localparam logic [1:0] ST_RESYNC = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic cs_p0, cs_p1, cs_p2;
  logic sclk_p0, sclk_p1, sclk_p2;
  logic mosi_p0, mosi_p1;

  logic [1:0]       state;
  logic [1:0]       fill;
  logic [CNT_W-1:0] cnt;
  logic [nbits-1:0] rx_sreg;
  logic [nbits-1:0] tx_sreg;
  logic [nbits-1:0] tx_buf;
  logic             tx_full;
  logic [nbits-1:0] rx_msg_q;
  logic             rx_val_q;
  logic             rx_overflow_q;
  logic             frame_err_q;

  logic cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic tx_wr, frame_start, frame_end, frame_good;

  // Synchronizer stages: _p0/_p1 resolve metastability, _p2 is the edge-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_p0   <= 1'b1;
      cs_p1   <= 1'b1;
      cs_p2   <= 1'b1;
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      cs_p0   <= bus.cs;
      cs_p1   <= cs_p0;
      cs_p2   <= cs_p1;
      sclk_p0 <= bus.sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      mosi_p0 <= bus.mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  assign cs_fall     = cs_p2 & ~cs_p1;
  assign cs_rise     = ~cs_p2 & cs_p1;
  assign sclk_rise   = ~sclk_p2 & sclk_p1;
  assign sclk_fall   = sclk_p2 & ~sclk_p1;
  assign tx_wr       = bus.tx_val & ~tx_full;
  assign frame_start = (state == ST_IDLE) & cs_fall;
  assign frame_end   = (state == ST_ACTIVE) & cs_rise;
  assign frame_good  = (cnt == CNT_FULL);

  // The cs synchronizer resets to 1, so RESYNC waits until it holds real pin
  // samples before trusting cs=1; otherwise a frame in progress would be joined.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RESYNC;
      fill    <= 2'd0;
      cnt     <= '0;
      rx_sreg <= '0;
      tx_sreg <= '0;
    end else begin
      case (state)
        ST_RESYNC: begin
          if (fill != 2'd2) fill <= fill + 2'd1;
          else if (cs_p1)   state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (cs_fall) begin
            state   <= ST_ACTIVE;
            tx_sreg <= tx_full ? tx_buf : '0;
            rx_sreg <= '0;
            cnt     <= '0;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) state <= ST_IDLE;
          if (sclk_rise) begin
            rx_sreg <= {rx_sreg[nbits-2:0], mosi_p1};
            if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
          end
          if (sclk_fall) tx_sreg <= {tx_sreg[nbits-2:0], 1'b0};
        end
        default: state <= ST_RESYNC;
      endcase
    end
  end

  // A write coinciding with frame_start lands after the load, so it waits for the next frame
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_full <= 1'b0;
    end else if (tx_wr) begin
      tx_full <= 1'b1;
    end else if (frame_start) begin
      tx_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_wr) tx_buf <= bus.tx_msg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_val_q      <= 1'b0;
      rx_msg_q      <= '0;
      rx_overflow_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      rx_overflow_q <= 1'b0;
      frame_err_q   <= 1'b0;
      if (rx_val_q && bus.rx_rdy) rx_val_q <= 1'b0;
      if (frame_end) begin
        if (!frame_good) begin
          frame_err_q <= 1'b1;
        end else if (!rx_val_q || bus.rx_rdy) begin
          rx_msg_q <= rx_sreg;
          rx_val_q <= 1'b1;
        end else begin
          rx_overflow_q <= 1'b1;
        end
      end
    end
  end

  assign bus.miso        = (state == ST_ACTIVE) & tx_sreg[nbits-1];
  assign bus.tx_rdy      = ~tx_full;
  assign bus.rx_val      = rx_val_q;
  assign bus.rx_msg      = rx_msg_q;
  assign bus.rx_overflow = rx_overflow_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_minion.sv
// Bench for spi_minion (nbits=8): directed SPI frames at clk/8 with a
// scoreboard queue of expected rx words popped by an independent monitor.
module tb_spi_minion;

  localparam int NB = 8;

  logic clk = 1'b0;
  logic reset;

  spi_minion_if #(.nbits(NB)) bus ();

  spi_minion #(.nbits(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  int ovf_cnt  = 0;
  logic [NB-1:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor samples at negedge: the values it sees are those the next posedge acts on
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_val && bus.rx_rdy) begin
        if (exp_q.size() == 0) check("rx_unexpected_word", {24'h0, bus.rx_msg}, 32'hxxxx_xxxx);
        else check("rx_msg", {24'h0, bus.rx_msg}, {24'h0, exp_q.pop_front()});
      end
      if (bus.frame_err)   ferr_cnt++;
      if (bus.rx_overflow) ovf_cnt++;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic load_tx(input logic [NB-1:0] v);
    check("tx_rdy_before_load", {31'h0, bus.tx_rdy}, 32'h1);
    bus.tx_val = 1'b1;
    bus.tx_msg = v;
    tick(1);
    bus.tx_val = 1'b0;
    check("tx_rdy_after_load", {31'h0, bus.tx_rdy}, 32'h0);
  endtask

  task automatic drain();
    bus.rx_rdy = 1'b1;
    tick(1);
    bus.rx_rdy = 1'b0;
  endtask

  // n sclk pulses; mosi driven MSB first, miso captured where the master samples it
  task automatic pulses(input logic [NB-1:0] d, input int n, output logic [NB-1:0] mb);
    mb = '0;
    for (int i = 0; i < n; i++) begin
      bus.mosi = (i < NB) ? d[NB-1-i] : 1'b0;
      tick(4);
      if (i < NB) mb[NB-1-i] = bus.miso;
      bus.sclk = 1'b1;
      tick(4);
      bus.sclk = 1'b0;
    end
    tick(4);
  endtask

  task automatic frame(input logic [NB-1:0] d, input int n, input logic rdy_at_end,
                       input logic wr_at_fall, input logic [NB-1:0] wmsg,
                       output logic [NB-1:0] mb);
    bus.cs = 1'b0;
    tick(2);
    if (wr_at_fall) begin
      bus.tx_val = 1'b1;
      bus.tx_msg = wmsg;
      tick(1);
      bus.tx_val = 1'b0;
      check("tx_rdy_after_fall_write", {31'h0, bus.tx_rdy}, 32'h0);
    end else begin
      tick(1);
    end
    tick(1);
    pulses(d, n, mb);
    bus.cs = 1'b1;
    if (rdy_at_end) begin
      tick(2);
      bus.rx_rdy = 1'b1;
      tick(1);
      bus.rx_rdy = 1'b0;
      tick(5);
    end else begin
      tick(8);
    end
  endtask

  logic [NB-1:0] mb;

  initial begin
    bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
    bus.tx_val = 1'b0; bus.tx_msg = '0; bus.rx_rdy = 1'b0;
    reset = 1'b1;
    tick(3);
    check("rst_miso", {31'h0, bus.miso}, 32'h0);
    check("rst_tx_rdy", {31'h0, bus.tx_rdy}, 32'h1);
    check("rst_rx_val", {31'h0, bus.rx_val}, 32'h0);
    check("rst_rx_msg", {24'h0, bus.rx_msg}, 32'h0);
    check("rst_overflow", {31'h0, bus.rx_overflow}, 32'h0);
    check("rst_frame_err", {31'h0, bus.frame_err}, 32'h0);
    reset = 1'b0;
    tick(6);

    // Preloaded A5 out, 3C in
    bus.rx_rdy = 1'b1;
    load_tx(8'hA5);
    exp_q.push_back(8'h3C);
    frame(8'h3C, 8, 1'b0, 1'b0, 8'h00, mb);
    check("miso_a5", {24'h0, mb}, 32'hA5);
    check("tx_rdy_back", {31'h0, bus.tx_rdy}, 32'h1);

    // Empty buffer sends zeros
    exp_q.push_back(8'hFF);
    frame(8'hFF, 8, 1'b0, 1'b0, 8'h00, mb);
    check("miso_zero", {24'h0, mb}, 32'h00);

    // Short and long frames
    bus.rx_rdy = 1'b0;
    frame(8'h5A, 7, 1'b0, 1'b0, 8'h00, mb);
    check("ferr_short", ferr_cnt, 1);
    check("rx_val_short", {31'h0, bus.rx_val}, 32'h0);
    frame(8'h5A, 9, 1'b0, 1'b0, 8'h00, mb);
    check("ferr_long", ferr_cnt, 2);
    check("rx_val_long", {31'h0, bus.rx_val}, 32'h0);

    // Overflow: second word dropped while first pending
    exp_q.push_back(8'h11);
    frame(8'h11, 8, 1'b0, 1'b0, 8'h00, mb);
    check("rx_val_pending", {31'h0, bus.rx_val}, 32'h1);
    frame(8'h22, 8, 1'b0, 1'b0, 8'h00, mb);
    check("ovf_count", ovf_cnt, 1);
    check("rx_msg_kept", {24'h0, bus.rx_msg}, 32'h11);
    drain();
    check("rx_val_drained", {31'h0, bus.rx_val}, 32'h0);

    // Consumer accepts on the completion cycle: no overflow, new word replaces
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    frame(8'h11, 8, 1'b0, 1'b0, 8'h00, mb);
    frame(8'h22, 8, 1'b1, 1'b0, 8'h00, mb);
    check("ovf_none", ovf_cnt, 1);
    check("rx_val_22", {31'h0, bus.rx_val}, 32'h1);
    check("rx_msg_22", {24'h0, bus.rx_msg}, 32'h22);
    drain();

    // Reset in the middle of a frame with cs held low
    frame(8'h77, 8, 1'b0, 1'b0, 8'h00, mb);
    check("rx_msg_77", {24'h0, bus.rx_msg}, 32'h77);
    load_tx(8'h5A);
    bus.cs = 1'b0;
    tick(4);
    pulses(8'hF0, 3, mb);
    check("miso_pre_reset", {24'h0, mb}, 32'h40);
    do_reset();
    check("mid_rst_tx_rdy", {31'h0, bus.tx_rdy}, 32'h1);
    check("mid_rst_rx_val", {31'h0, bus.rx_val}, 32'h0);
    check("mid_rst_rx_msg", {24'h0, bus.rx_msg}, 32'h0);
    check("mid_rst_miso", {31'h0, bus.miso}, 32'h0);
    pulses(8'hF0, 5, mb);
    check("miso_ignored", {24'h0, mb}, 32'h00);
    bus.cs = 1'b1;
    tick(8);
    check("ferr_after_rst", ferr_cnt, 2);
    check("rx_val_after_rst", {31'h0, bus.rx_val}, 32'h0);
    bus.rx_rdy = 1'b1;
    exp_q.push_back(8'h96);
    frame(8'h96, 8, 1'b0, 1'b0, 8'h00, mb);
    check("miso_after_rst", {24'h0, mb}, 32'h00);

    // Write on the same cycle the frame starts
    exp_q.push_back(8'h01);
    frame(8'h01, 8, 1'b0, 1'b1, 8'hC3, mb);
    check("miso_coincident", {24'h0, mb}, 32'h00);
    check("tx_rdy_still_full", {31'h0, bus.tx_rdy}, 32'h0);
    exp_q.push_back(8'h02);
    frame(8'h02, 8, 1'b0, 1'b0, 8'h00, mb);
    check("miso_c3", {24'h0, mb}, 32'hC3);
    check("tx_rdy_final", {31'h0, bus.tx_rdy}, 32'h1);

    tick(4);
    check("scoreboard_empty", exp_q.size(), 0);
    check("ferr_total", ferr_cnt, 2);
    check("ovf_total", ovf_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
